logic_op_scheduler: RTL

Shares a single instance of the 32-bit logic/extension datapath between two requesters, e.g. the core execute stage and a custom-instruction/DMA helper. Arbitration is round-robin. Operands are captured into registers, the operation runs for one cycle, and the result is returned on one registered response channel with valid/ready backpressure. A saturating counter of completed operations is exposed for performance monitoring.

---
 rtl/logic_op_scheduler.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/logic_op_scheduler.sv
// logic_op_scheduler
//   Shares one 32-bit logic/extension datapath between two requesters.
//   Arbitration is round-robin. Operands are captured on the grant edge.
//   The operation is evaluated for one cycle (EXEC), and the result is
//   returned on a registered response channel (RESP) with backpressure.
//
// Handshakes:
//   Request side: reqN is a level request. gntN is a one-cycle combinational
//   accept pulse, and the operands are captured on that clock edge. A reqN
//   still high on the cycle after gntN counts as a fresh request.
//   Response side: a transfer happens on any rising edge with
//   rspValid && rspReady. rspValid, rspId and rspData are held stable until
//   that edge.
//
// Ports:
//   clock, nReset          clock and asynchronous active-low reset
//   req0/1, op0/1          request valid and 3-bit opcode per requester
//   a0, b0, a1, b1         32-bit operands per requester
//   gnt0, gnt1             combinational grant pulses (0 while in reset)
//   rspValid/rspId/rspData registered response channel
//   rspReady               consumer accepts the response
//   busy                   FSM is not in IDLE
//   opCount                saturating count of completed responses
module logic_op_scheduler #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             nReset,
    input  logic             req0,
    input  logic             req1,
    input  logic [2:0]       op0,
    input  logic [2:0]       op1,
    input  logic [31:0]      a0,
    input  logic [31:0]      b0,
    input  logic [31:0]      a1,
    input  logic [31:0]      b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rspValid,
    output logic             rspId,
    output logic [31:0]      rspData,
    input  logic             rspReady,
    output logic             busy,
    output logic [CNT_W-1:0] opCount
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_rrPtr;
    logic [2:0]        r_op;
    logic [31:0]       r_a;
    logic [31:0]       r_b;
    logic              r_id;
    logic              r_rspValid;
    logic              r_rspId;
    logic [31:0]       r_rspData;
    logic [CNT_W-1:0]  r_opCount;

    logic              w_any;
    logic              w_sel1;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_fire;
    logic [31:0]       w_result;

    // Requester 1 wins when it is the only one asking, or on a tie when
    // the round-robin pointer favours it.
    assign w_any  = req0 | req1;
    assign w_sel1 = req1 & (~req0 | r_rrPtr);
    assign w_fire = (r_state == S_RESP) & rspReady;

    // State register
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next = S_EXEC;
            S_EXEC:  w_next = S_RESP;
            S_RESP:  if (rspReady) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic: grants only in IDLE, independent of rspReady
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (r_state == S_IDLE && w_any) begin
            w_gnt0 = ~w_sel1;
            w_gnt1 = w_sel1;
        end
    end

    // Grants are gated with reset so nothing is accepted while held in reset
    assign gnt0 = w_gnt0 & nReset;
    assign gnt1 = w_gnt1 & nReset;
    assign busy = (r_state != S_IDLE);

    // Operand capture on the grant edge
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            r_op <= 3'd0;
            r_a  <= 32'd0;
            r_b  <= 32'd0;
            r_id <= 1'b0;
        end else if (r_state == S_IDLE && w_any) begin
            r_op <= w_sel1 ? op1 : op0;
            r_a  <= w_sel1 ? a1 : a0;
            r_b  <= w_sel1 ? b1 : b0;
            r_id <= w_sel1;
        end
    end

    // Shared logic/extension datapath
    always_comb begin
        w_result = 32'd0;
        case (r_op)
            3'b001:  w_result = r_a & r_b;
            3'b010:  w_result = r_a | r_b;
            3'b011:  w_result = r_a ^ r_b;
            3'b100:  w_result = {{16{r_a[15]}}, r_a[15:0]};
            3'b101:  w_result = {{24{r_a[7]}}, r_a[7:0]};
            3'b110:  w_result = {16'd0, r_a[15:0]};
            3'b111:  w_result = {24'd0, r_a[7:0]};
            default: w_result = 32'd0;
        endcase
    end

    // Response channel, round-robin pointer and completion counter
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            r_rspValid <= 1'b0;
            r_rspId    <= 1'b0;
            r_rspData  <= 32'd0;
            r_rrPtr    <= 1'b0;
            r_opCount  <= '0;
        end else begin
            if (r_state == S_EXEC) begin
                r_rspValid <= 1'b1;
                r_rspId    <= r_id;
                r_rspData  <= w_result;
            end else if (w_fire) begin
                r_rspValid <= 1'b0;
                // The requester just served loses the next tie
                r_rrPtr    <= ~r_rspId;
                if (!(&r_opCount)) begin
                    r_opCount <= r_opCount + 1'b1;
                end
            end
        end
    end

    assign rspValid = r_rspValid;
    assign rspId    = r_rspId;
    assign rspData  = r_rspData;
    assign opCount  = r_opCount;

endmodule
